// File: rtl/argmax_pkg.sv
// argmax_pkg
// Shared definitions for the argmax streaming block:
//   - state_t      : controller states (ACCUM, EMIT, EMIT_VAL)
//   - LEN_ERR_BIT  : bit position of the length-error flag in the result word
//   - FP32_W       : width of an IEEE-754 single-precision word
//   - fp32_key()   : maps a float32 bit pattern to an unsigned key whose
//                    integer order matches the float order. One consequence
//                    is that -0.0 ranks below +0.0, +NaN ranks above +inf and
//                    -NaN ranks below -inf.
package argmax_pkg;

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        EMIT     = 2'd1,
        EMIT_VAL = 2'd2
    } state_t;

    localparam int LEN_ERR_BIT = 31;
    localparam int FP32_W      = 32;

    // Negative numbers are bit-inverted, so a larger magnitude gives a smaller key.
    // Positive numbers get their sign bit set, which lifts them above every negative.
    function automatic logic [FP32_W-1:0] fp32_key(input logic [FP32_W-1:0] x);
        return x[FP32_W-1] ? ~x : (x ^ 32'h8000_0000);
    endfunction

endpackage

// File: rtl/fp32_max_cmp.sv
// fp32_max_cmp
// Combinational float32 "greater than" built on the fp32_key ordering.
// Ports:
//   a      : float32 candidate
//   b      : float32 reference
//   a_gt_b : 1 when key(a) > key(b), unsigned compare (strict, so equal keys give 0)
module fp32_max_cmp
    import argmax_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic              a_gt_b
);

    assign a_gt_b = (fp32_key(a) > fp32_key(b));

endmodule

// File: rtl/argmax_stream.sv
// argmax_stream
// Consumes a float32 score vector over AXI4-Stream (TLAST ends the vector),
// tracks the running maximum and, one cycle after the TLAST beat, emits a
// result word: bits [IDX_W-1:0] hold the index of the largest element,
// bit 31 flags a vector whose length differs from COLS.
// Optional build macro ARGMAX_EMIT_VALUE_EN: the index word is sent with
// TLAST=0 and is followed by the raw float32 maximum with TLAST=1.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   INPUT_AXIS_*       : score stream in (TDATA, TLAST, TVALID, TREADY)
//   OUTPUT_AXIS_*      : result stream out (TDATA, TLAST, TVALID, TREADY)
module argmax_stream
    import argmax_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int IDX_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FP32_W-1:0] INPUT_AXIS_TDATA,
    input  logic              INPUT_AXIS_TLAST,
    input  logic              INPUT_AXIS_TVALID,
    output logic              INPUT_AXIS_TREADY,
    output logic [FP32_W-1:0] OUTPUT_AXIS_TDATA,
    output logic              OUTPUT_AXIS_TLAST,
    output logic              OUTPUT_AXIS_TVALID,
    input  logic              OUTPUT_AXIS_TREADY
);

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  max_idx;
    logic [FP32_W-1:0] max_val;

    logic              beat;
    logic              x_gt_max;
    logic              take_new;
    logic [IDX_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  idx_sel;
    logic              len_err;
    logic [FP32_W-1:0] result_word;

    // Ready is a pure state decode so it never combinationally depends on TVALID.
    assign INPUT_AXIS_TREADY = (state == ACCUM);
    assign beat              = INPUT_AXIS_TVALID && INPUT_AXIS_TREADY;

    fp32_max_cmp u_cmp (
        .a      (INPUT_AXIS_TDATA),
        .b      (max_val),
        .a_gt_b (x_gt_max)
    );

    // Next-count, winner selection and result word for the beat in flight.
    // The TLAST beat itself takes part in the comparison, so the result is
    // assembled from the post-beat values and registered on the same edge.
    always_comb begin
        cnt_next    = (cnt == {IDX_W{1'b1}}) ? cnt : cnt + IDX_W'(1);
        take_new    = (cnt == '0) || x_gt_max;
        idx_sel     = take_new ? cnt : max_idx;
        len_err     = (32'(cnt_next) != 32'(COLS));
        result_word = '0;
        result_word[IDX_W-1:0]   = idx_sel;
        result_word[LEN_ERR_BIT] = len_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ACCUM;
            cnt                <= '0;
            max_idx            <= '0;
            max_val            <= '0;
            OUTPUT_AXIS_TDATA  <= '0;
            OUTPUT_AXIS_TLAST  <= 1'b0;
            OUTPUT_AXIS_TVALID <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        if (take_new) begin
                            max_val <= INPUT_AXIS_TDATA;
                            max_idx <= cnt;
                        end
                        cnt <= cnt_next;
                        if (INPUT_AXIS_TLAST) begin
                            state              <= EMIT;
                            OUTPUT_AXIS_TDATA  <= result_word;
                            OUTPUT_AXIS_TVALID <= 1'b1;
`ifdef ARGMAX_EMIT_VALUE_EN
                            OUTPUT_AXIS_TLAST  <= 1'b0;
`else
                            OUTPUT_AXIS_TLAST  <= 1'b1;
`endif
                        end
                    end
                end

                EMIT: begin
                    if (OUTPUT_AXIS_TREADY) begin
`ifdef ARGMAX_EMIT_VALUE_EN
                        // Index word accepted; follow up with the raw maximum.
                        state             <= EMIT_VAL;
                        OUTPUT_AXIS_TDATA <= max_val;
                        OUTPUT_AXIS_TLAST <= 1'b1;
`else
                        state              <= ACCUM;
                        cnt                <= '0;
                        OUTPUT_AXIS_TDATA  <= '0;
                        OUTPUT_AXIS_TLAST  <= 1'b0;
                        OUTPUT_AXIS_TVALID <= 1'b0;
`endif
                    end
                end

`ifdef ARGMAX_EMIT_VALUE_EN
                EMIT_VAL: begin
                    if (OUTPUT_AXIS_TREADY) begin
                        state              <= ACCUM;
                        cnt                <= '0;
                        OUTPUT_AXIS_TDATA  <= '0;
                        OUTPUT_AXIS_TLAST  <= 1'b0;
                        OUTPUT_AXIS_TVALID <= 1'b0;
                    end
                end
`endif

                default: begin
                    state              <= ACCUM;
                    cnt                <= '0;
                    OUTPUT_AXIS_TVALID <= 1'b0;
                    OUTPUT_AXIS_TLAST  <= 1'b0;
                    OUTPUT_AXIS_TDATA  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_stream.sv
// tb_argmax_stream
// Directed testbench for argmax_stream (COLS=4, IDX_W=16). Expected result
// words are hand-computed constants. Also exercises fp32_max_cmp directly on
// the signed-zero and NaN/inf ordering corners.
module tb_argmax_stream;

    logic        clk;
    logic        rst;
    logic [31:0] in_tdata;
    logic        in_tlast;
    logic        in_tvalid;
    logic        in_tready;
    logic [31:0] out_tdata;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;

    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic        cmp_gt;

    logic [31:0] vec [0:7];

    int checks;
    int errors;

    argmax_stream #(
        .COLS  (4),
        .IDX_W (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .INPUT_AXIS_TDATA   (in_tdata),
        .INPUT_AXIS_TLAST   (in_tlast),
        .INPUT_AXIS_TVALID  (in_tvalid),
        .INPUT_AXIS_TREADY  (in_tready),
        .OUTPUT_AXIS_TDATA  (out_tdata),
        .OUTPUT_AXIS_TLAST  (out_tlast),
        .OUTPUT_AXIS_TVALID (out_tvalid),
        .OUTPUT_AXIS_TREADY (out_tready)
    );

    fp32_max_cmp u_ref_cmp (
        .a      (cmp_a),
        .b      (cmp_b),
        .a_gt_b (cmp_gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence below.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Presents one word and holds it until the DUT accepts it on a clock edge.
    // Called and returns at posedge+1.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        int waited;
        waited    = 0;
        in_tdata  = data;
        in_tlast  = last;
        in_tvalid = 1'b1;
        while (in_tready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_tready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: observed tready=%b expected 1", in_tready);
        end
        @(posedge clk); #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    // Sends vec[0..n-1]; just before the TLAST beat the output must still be idle.
    task automatic sendVector(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1)
                checkFlag({tag, "_idle_before_last"}, out_tvalid, 1'b0);
            applyStimulus(vec[i], (i == n - 1));
        end
    endtask

    // Called at posedge+1 right after the TLAST beat; valid must already be up.
    task automatic expectResult(input string tag, input logic [31:0] exp_word, input logic [31:0] exp_val);
        checkFlag({tag, "_valid"}, out_tvalid, 1'b1);
        checkOutput({tag, "_index"}, out_tdata, exp_word);
`ifdef ARGMAX_EMIT_VALUE_EN
        checkFlag({tag, "_tlast_index"}, out_tlast, 1'b0);
        @(posedge clk); #1;
        checkFlag({tag, "_valid_value"}, out_tvalid, 1'b1);
        checkOutput({tag, "_value"}, out_tdata, exp_val);
        checkFlag({tag, "_tlast_value"}, out_tlast, 1'b1);
`else
        checkFlag({tag, "_tlast"}, out_tlast, 1'b1);
        $display("[TB] %s: max value of this vector is 0x%08h", tag, exp_val);
`endif
        @(posedge clk); #1;
        checkFlag({tag, "_valid_drop"}, out_tvalid, 1'b0);
        checkFlag({tag, "_in_ready"}, in_tready, 1'b1);
    endtask

    task automatic runVector4(input string tag,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] exp_word, input logic [31:0] exp_val);
        vec[0] = w0; vec[1] = w1; vec[2] = w2; vec[3] = w3;
        sendVector(tag, 4);
        expectResult(tag, exp_word, exp_val);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_tdata   = '0;
        in_tlast   = 1'b0;
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        cmp_a      = '0;
        cmp_b      = '0;
        for (int i = 0; i < 8; i++) vec[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkFlag("reset_valid", out_tvalid, 1'b0);
        checkOutput("reset_data", out_tdata, 32'h0000_0000);
        checkFlag("reset_tlast", out_tlast, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkFlag("reset_in_ready", in_tready, 1'b1);

        // Comparator ordering corners
        cmp_a = 32'h0000_0000; cmp_b = 32'h8000_0000; #1;
        checkFlag("cmp_pos0_gt_neg0", cmp_gt, 1'b1);
        cmp_a = 32'h8000_0000; cmp_b = 32'h0000_0000; #1;
        checkFlag("cmp_neg0_gt_pos0", cmp_gt, 1'b0);
        cmp_a = 32'h7FC0_0000; cmp_b = 32'h7F80_0000; #1;
        checkFlag("cmp_pnan_gt_pinf", cmp_gt, 1'b1);
        cmp_a = 32'hFFC0_0000; cmp_b = 32'hFF80_0000; #1;
        checkFlag("cmp_nnan_gt_ninf", cmp_gt, 1'b0);
        cmp_a = 32'h4000_0000; cmp_b = 32'h4000_0000; #1;
        checkFlag("cmp_equal", cmp_gt, 1'b0);
        cmp_a = 32'hBF00_0000; cmp_b = 32'hBF80_0000; #1;
        checkFlag("cmp_neg_half_gt_neg_one", cmp_gt, 1'b1);
        @(posedge clk); #1;

        // Test 1: ascending positives, max at the last index
        runVector4("t1_ascending", 32'h4073_3334, 32'h408C_CCCD, 32'h40A0_0000, 32'h40B3_3334,
                   32'h0000_0003, 32'h40B3_3334);

        // Test 2: all negatives, then a tie that must keep the earliest index
        runVector4("t2_negatives", 32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000, 32'hC040_0000,
                   32'h0000_0001, 32'hBF00_0000);
        runVector4("t2_tie", 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0000,
                   32'h0000_0000, 32'h4000_0000);

        // Signed zero and NaN/inf ordering through the whole datapath
        runVector4("zero_sign", 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000,
                   32'h0000_0001, 32'h0000_0000);
        runVector4("pos_nan", 32'h7F80_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'hFFC0_0000,
                   32'h0000_0001, 32'h7FC0_0000);
        runVector4("neg_nan", 32'hFFC0_0000, 32'hFF80_0000, 32'hFFC0_0000, 32'hFFC0_0000,
                   32'h0000_0001, 32'hFF80_0000);

        // Test 3: short and long vectors raise the length error
        vec[0] = 32'h3F80_0000; vec[1] = 32'h4110_0000; vec[2] = 32'h4000_0000;
        sendVector("t3_short", 3);
        expectResult("t3_short", 32'h8000_0001, 32'h4110_0000);
        vec[0] = 32'h3F80_0000; vec[1] = 32'h4000_0000; vec[2] = 32'h4040_0000;
        vec[3] = 32'h4080_0000; vec[4] = 32'h4120_0000;
        sendVector("t3_long", 5);
        expectResult("t3_long", 32'h8000_0004, 32'h4120_0000);

        // Single-word vector
        vec[0] = 32'hC0A0_0000;
        sendVector("single", 1);
        expectResult("single", 32'h8000_0000, 32'hC0A0_0000);

        // Test 4: downstream stalls 5 cycles while the next word is already offered
        out_tready = 1'b0;
        vec[0] = 32'h4073_3334; vec[1] = 32'h408C_CCCD; vec[2] = 32'h40A0_0000; vec[3] = 32'h40B3_3334;
        sendVector("t4_stall", 4);
        in_tdata  = 32'h41F0_0000;
        in_tlast  = 1'b0;
        in_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkFlag("t4_stall_valid", out_tvalid, 1'b1);
            checkOutput("t4_stall_data", out_tdata, 32'h0000_0003);
            checkFlag("t4_stall_in_ready", in_tready, 1'b0);
            @(posedge clk); #1;
        end
        out_tready = 1'b1;
        expectResult("t4_release", 32'h0000_0003, 32'h40B3_3334);
        applyStimulus(32'h41F0_0000, 1'b0);
        applyStimulus(32'h3F80_0000, 1'b0);
        applyStimulus(32'h4000_0000, 1'b0);
        checkFlag("t4_next_idle_before_last", out_tvalid, 1'b0);
        applyStimulus(32'h4040_0000, 1'b1);
        expectResult("t4_next", 32'h0000_0000, 32'h41F0_0000);

        // Test 5: asynchronous reset mid-vector discards the partial vector
        applyStimulus(32'h4073_3334, 1'b0);
        applyStimulus(32'h408C_CCCD, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkFlag("t5_reset_valid", out_tvalid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkFlag("t5_after_reset_valid", out_tvalid, 1'b0);
        checkFlag("t5_after_reset_in_ready", in_tready, 1'b1);
        runVector4("t5_fresh", 32'h4073_3334, 32'h408C_CCCD, 32'h40A0_0000, 32'h40B3_3334,
                   32'h0000_0003, 32'h40B3_3334);
        repeat (3) @(posedge clk);
        #1;
        checkFlag("t5_no_extra_output", out_tvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Downstream consumer of the dot-product stage's output vector: one float32 (IEEE-754 single) word per beat over AXI4-Stream, vector terminated by TLAST.
- Tracks the running maximum across the vector.
- After the last beat, emits one result word carrying the index of the largest element and a length-error flag.
- Sits between dot and the host/DMA return path; turns a classifier's score vector into a class index.

Parameters:
- COLS, 4, expected vector length (number of dot outputs); used only for the length check.
- IDX_W, 16, width of the index counter/result field; must be ≤ 31.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- INPUT_AXIS_TDATA  input  32  float32 score word
- INPUT_AXIS_TLAST  input  1  last element of vector
- INPUT_AXIS_TVALID  input  1  input word valid
- INPUT_AXIS_TREADY  output  1  block can accept input
- OUTPUT_AXIS_TDATA  output  32  result word
- OUTPUT_AXIS_TLAST  output  1  last result word of vector
- OUTPUT_AXIS_TVALID  output  1  result valid
- OUTPUT_AXIS_TREADY  input  1  downstream can accept

Behaviour:
- Reset values:
  - state=ACCUM; all counters and registers zero.
  - OUTPUT_AXIS_TVALID=0, OUTPUT_AXIS_TDATA=0, OUTPUT_AXIS_TLAST=0.
  - INPUT_AXIS_TREADY=1 once out of reset.
- Reset is asynchronous. Asserting rst mid-vector or mid-emit discards all partial state; no output is produced for that vector.
- States:
  - ACCUM: INPUT_AXIS_TREADY=1, a registered/state decode that never depends on TVALID.
  - EMIT: INPUT_AXIS_TREADY=0, OUTPUT_AXIS_TVALID=1.
- Beat = TVALID && TREADY. On each accepted beat in ACCUM:
  - Compute key(x): if x[31]=1 then key=~x, else key=x^32'h8000_0000.
  - On the first beat of a vector (cnt==0), or when key(x) > key(max) as an unsigned compare: max<=x, max_idx<=cnt.
  - Strict greater-than, so ties keep the earliest index.
  - cnt<=cnt+1, saturating at 2^IDX_W-1.
- Ordering consequences of the key transform, to be kept as is:
  - -0.0 < +0.0.
  - +NaN ranks above +inf; -NaN ranks below -inf.
- TLAST beat: it is included in the comparison in the same cycle. Next state=EMIT. Output registers load on that edge, so TVALID rises the cycle after the TLAST beat (latency 1).
- Result word:
  - TDATA[IDX_W-1:0] = max_idx.
  - TDATA[31] = len_err, where len_err = (final count != COLS); final count includes the TLAST beat.
  - All other bits 0.
  - TLAST=1.
- EMIT:
  - TDATA, TLAST and TVALID are held stable until OUTPUT_AXIS_TREADY=1.
  - On that handshake: cnt<=0, state=ACCUM, TVALID=0 on the next cycle.
- Throughput: one input word per cycle in ACCUM, plus at least one bubble cycle per vector for EMIT.
- A single-word vector (TLAST on the first beat) is legal: index 0, len_err = (COLS != 1).
- Input words presented during EMIT are not accepted, because TREADY=0.

Optional Feature:
- Macro: ARGMAX_EMIT_VALUE_EN.
- When defined, EMIT sends two words:
  - Index word with TLAST=0.
  - Then an EMIT_VAL state that sends the raw float32 max value with TLAST=1.
  - Each word needs its own handshake.
  - Return to ACCUM only after the second handshake.
- When undefined, only the index word is sent (TLAST=1) and the EMIT_VAL state and its logic do not exist.

Decomposition:
- Package argmax_pkg holds:
  - state enum (ACCUM, EMIT, EMIT_VAL);
  - constants LEN_ERR_BIT=31 and FP32_W=32;
  - function fp32_key() implementing the key transform.
- One sub-module, fp32_max_cmp: combinational. Inputs are two float32 words; output is a_gt_b using fp32_key. It is instantiated once in argmax_stream and reused by the bench's reference checker.

Test Plan:
1. Send {0x40733334 (3.8), 0x408CCCCD (4.4), 0x40A00000 (5.0), 0x40B33334 (5.6)}, TLAST on the 4th, OUTPUT_AXIS_TREADY=1 → one word 0x0000_0003, TLAST=1; TVALID rises exactly 1 cycle after the TLAST beat.
2. Send {-1.0 (0xBF800000), -0.5 (0xBF000000), -2.0, -3.0} → 0x0000_0001. Then, for the tie case, send {2.0, 2.0, 1.0, 0.0} → 0x0000_0000.
3. Send 3 words {1.0, 9.0, 2.0} with TLAST on the 3rd (COLS=4) → 0x8000_0001. Then send 5 words with max at index 4 → 0x8000_0004.
4. Hold OUTPUT_AXIS_TREADY=0 for 5 cycles after vector 1 → TVALID stays 1, TDATA stable, INPUT_AXIS_TREADY stays 0. The next vector's words are not accepted until the handshake.
5. Assert rst after 2 of 4 words, release, then send the full vector from test 1 → exactly one output, 0x0000_0003; no stale result.
6. With ARGMAX_EMIT_VALUE_EN defined, run test 1 → word 0x0000_0003 with TLAST=0, then 0x40B33334 with TLAST=1.
